led_seq: RTL and testbench

LED_SEQ -- requirements
Module: led_seq

---
 rtl/led_pkg.sv | 34 +++
 rtl/led_tick_div.sv | 40 ++++
 rtl/led_seq.sv | 126 ++++++++++++
 tb/tb_led_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED sequencer types: LED codes, request modes, FSM states.
// Also used by the downstream LED decoder.
package led_pkg;

  localparam logic [1:0] LED_OFF = 2'b00;
  localparam logic [1:0] LED_ALL = 2'b01;
  localparam logic [1:0] LED_MID = 2'b10;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_ALL   = 2'b01,
    MODE_MID   = 2'b10,
    MODE_ALT   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_GAP  = 2'b10
  } state_e;

  function automatic logic [1:0] on_code(
    input mode_e m
  );
    return (m == MODE_MID) ? LED_MID : LED_ALL;
  endfunction

  function automatic logic [1:0] gap_code(
    input mode_e m
  );
    return (m == MODE_ALT) ? LED_MID : LED_OFF;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Phase timer: counts TICK_DIV cycles per blink phase.
// Flags the last and second-to-last cycle of each phase.
module led_tick_div #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic pre_o,
  output logic end_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] PRE  = TW'(TICK_DIV - 2);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pre_o = (cnt_q == PRE);
  assign end_o = (cnt_q == LAST);

endmodule

// File: rtl/led_seq.sv
// LED blink sequencer: ON/GAP phases per request, abort,
// back-to-back acceptance in the done cycle.
module led_seq
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int NBLINK   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [1:0] led_out
);

  localparam int BW = (NBLINK > 1) ? $clog2(NBLINK) : 1;
  localparam logic [BW-1:0] BLAST = BW'(NBLINK - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0]    led_q, led_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;

  logic accept;
  logic clr;
  logic ph_pre;
  logic ph_end;
  logic last_blink;
  logic final_d;

  assign accept     = req_valid & rdy_q & ~abort;
  assign clr        = accept | abort;
  assign last_blink = (blink_q == BLAST);

  led_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(clr),
    .en_i (state_q != S_IDLE),
    .pre_o(ph_pre),
    .end_o(ph_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_CLEAR;
      blink_q <= '0;
      led_q   <= LED_OFF;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    blink_d = blink_q;
    if (abort) begin
      state_d = S_IDLE;
      blink_d = '0;
    end else begin
      unique case (state_q)
        S_ON: begin
          if (ph_end) state_d = S_GAP;
        end
        S_GAP: begin
          if (ph_end) begin
            if (last_blink) begin
              state_d = S_IDLE;
              blink_d = '0;
            end else begin
              state_d = S_ON;
              blink_d = blink_q + BW'(1);
            end
          end
        end
        default: ;
      endcase
      if (accept) begin
        mode_d  = mode_e'(req_mode);
        blink_d = '0;
        state_d = (req_mode == MODE_CLEAR) ? S_IDLE : S_ON;
      end
    end
  end

  // The last GAP cycle is registered as done and ready so a
  // new request can chain without an idle cycle.
  always_comb begin
    final_d = (state_q == S_GAP) & last_blink & ph_pre & ~abort;
    done_d  = final_d | (accept & (req_mode == MODE_CLEAR));
    busy_d  = (state_d != S_IDLE);
    rdy_d   = (state_d == S_IDLE) | final_d;
    led_d   = LED_OFF;
    unique case (state_d)
      S_ON:    led_d = on_code(mode_d);
      S_GAP:   led_d = gap_code(mode_d);
      default: led_d = LED_OFF;
    endcase
  end

  assign req_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_led_seq.sv
// Directed scoreboard bench for led_seq with TICK_DIV=4, NBLINK=2.
// Expected outputs are queued per cycle and popped after each edge.
module tb_led_seq;

  localparam int TD  = 4;
  localparam int NB  = 2;
  localparam int LEN = 2 * TD * NB;

  typedef struct packed {
    logic [1:0] led;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] led_out;

  exp_t  sb[$];
  int    n_tests;
  int    n_fail;
  string phase;

  led_seq #(
    .TICK_DIV(TD),
    .NBLINK  (NB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_mode (req_mode),
    .req_ready(req_ready),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .led_out  (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [1:0] obs,
    input logic [1:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s t=%0t got=%0h want=%0h",
             phase, tag, $time, obs, exp);
    end
  endtask

  task automatic push(
    input logic [1:0] l,
    input logic       d,
    input logic       b,
    input logic       r
  );
    exp_t e;
    e.led   = l;
    e.done  = d;
    e.busy  = b;
    e.ready = r;
    sb.push_back(e);
  endtask

  task automatic push_idle();
    push(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic blink_exp(
    input logic [1:0] on,
    input logic [1:0] gap,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      push(((i / TD) % 2 == 0) ? on : gap,
           i == LEN - 1, 1'b1, i == LEN - 1);
    end
  endtask

  task automatic drive(
    input logic       v,
    input logic [1:0] m,
    input logic       ab
  );
    req_valid = v;
    req_mode  = m;
    abort     = ab;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("sb_empty", 2'(sb.size() == 0), 2'b00);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("led", led_out, e.led);
      chk("done", {1'b0, done}, {1'b0, e.done});
      chk("busy", {1'b0, busy}, {1'b0, e.busy});
      chk("ready", {1'b0, req_ready}, {1'b0, e.ready});
      chk("led11", 2'(led_out == 2'b11), 2'b00);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    phase   = "reset";
    rst_n   = 1'b1;
    drive(1'b0, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("led", led_out, 2'b00);
    chk("done", {1'b0, done}, 2'b00);
    chk("busy", {1'b0, busy}, 2'b00);
    chk("ready", {1'b0, req_ready}, 2'b00);
    @(posedge clk);
    #1;
    chk("ready_held", {1'b0, req_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    phase = "idle";
    repeat (3) begin
      push_idle();
      tick();
    end

    phase = "flash_all";
    drive(1'b1, 2'b01, 1'b0);
    blink_exp(2'b01, 2'b00, LEN);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (LEN - 1) tick();
    push_idle();
    tick();

    phase = "alt_b2b";
    drive(1'b1, 2'b11, 1'b0);
    blink_exp(2'b01, 2'b10, LEN);
    tick();
    drive(1'b1, 2'b10, 1'b0);
    repeat (LEN - 1) tick();
    blink_exp(2'b10, 2'b00, LEN);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (LEN - 1) tick();
    push_idle();
    tick();

    phase = "abort_mid";
    drive(1'b1, 2'b10, 1'b0);
    blink_exp(2'b10, 2'b00, 6);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (5) tick();
    drive(1'b0, 2'b00, 1'b1);
    push_idle();
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (2) begin
      push_idle();
      tick();
    end

    phase = "abort_req";
    drive(1'b1, 2'b01, 1'b1);
    push_idle();
    tick();
    drive(1'b0, 2'b00, 1'b0);
    push_idle();
    tick();

    phase = "clear";
    drive(1'b1, 2'b00, 1'b0);
    push(2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b01, 1'b0);
    blink_exp(2'b01, 2'b00, LEN);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (2) tick();
    drive(1'b1, 2'b01, 1'b0);
    tick();
    drive(1'b1, 2'b00, 1'b0);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (LEN - 5) tick();
    push_idle();
    tick();

    phase = "async_rst";
    drive(1'b1, 2'b01, 1'b0);
    blink_exp(2'b01, 2'b00, 6);
    tick();
    drive(1'b0, 2'b00, 1'b0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("led", led_out, 2'b00);
    chk("done", {1'b0, done}, 2'b00);
    chk("busy", {1'b0, busy}, 2'b00);
    chk("ready", {1'b0, req_ready}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TD * 3) begin
      push_idle();
      tick();
    end

    phase = "end";
    chk("sb_left", 2'(sb.size() != 0), 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
